// File: rtl/quiz_pkg.sv
// Shared definitions for the quiz game controller: FSM state encoding and timer width.
package quiz_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_ENTRY  = 3'd3,
        ST_JUDGE  = 3'd4,
        ST_RESULT = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    localparam int TIMER_W = 8;

endpackage

// File: rtl/quiz_ctrl_digit_entry.sv
// BCD answer entry: left-shifting nibble register with a digit count, clear has priority.
module digit_entry #(
    parameter int N_DIGITS = 6,
    parameter int CNT_W    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  shift,
    input  logic [3:0]            digit,
    output logic [4*N_DIGITS-1:0] entry,
    output logic [CNT_W-1:0]      count
);

    localparam int E_W = 4 * N_DIGITS;

    // Shift register and digit counter; non-BCD digits and overflow digits are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entry <= '0;
            count <= '0;
        end else if (clr) begin
            entry <= '0;
            count <= '0;
        end else if (shift && (digit <= 4'd9) && (count < CNT_W'(N_DIGITS))) begin
            entry <= (entry << 4) | E_W'(digit);
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/quiz_ctrl.sv
// Quiz game controller: question fetch, buzzer arbitration, answer entry, judging and scoring.
// Optional build macro QUIZ_PENALTY_EN: wrong answers decrement the answering player's score.
module quiz_ctrl
    import quiz_pkg::*;
#(
    parameter int N_PLAYERS  = 2,
    parameter int N_DIGITS   = 6,
    parameter int TIME_LIMIT = 30,
    parameter int ROUNDS     = 5,
    parameter int SCORE_W    = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          START,
    input  logic                          TICK,
    input  logic [4*N_DIGITS-1:0]         QUE_DATA,
    input  logic                          QUE_VALID,
    output logic                          QUE_REQ,
    input  logic [N_PLAYERS-1:0]          BUZZ,
    input  logic                          DIGIT_VALID,
    input  logic [3:0]                    DIGIT,
    input  logic                          CLR,
    input  logic                          ENTER,
    output logic [2:0]                    STATE,
    output logic [2:0]                    ACTIVE,
    output logic [4*N_DIGITS-1:0]         ENTRY,
    output logic [7:0]                    TIME_LEFT,
    output logic [SCORE_W*N_PLAYERS-1:0]  SCORE,
    output logic                          OK,
    output logic                          NG,
    output logic                          GAME_OVER
);

    localparam int CNT_W = $clog2(N_DIGITS + 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    state_t                         state_r, state_nx;
    logic [7:0]                     round_r, round_nx;
    logic [4*N_DIGITS-1:0]          answer_r, answer_nx;
    logic [TIMER_W-1:0]             time_r, time_nx;
    logic [N_PLAYERS-1:0]           lock_r, lock_nx;
    logic [2:0]                     active_r, active_nx;
    logic [SCORE_W*N_PLAYERS-1:0]   score_r, score_nx;
    logic [1:0]                     res_r, res_nx;
    logic                           ok_r, ok_nx, ng_r, ng_nx, req_r, req_nx, go_r;

    logic [4*N_DIGITS-1:0]          entry_s;
    logic [CNT_W-1:0]               count_s;
    logic                           entry_clr_s, entry_shift_s;
    logic [N_PLAYERS-1:0]           avail_s, active_oh_s;
    logic [2:0]                     pick_s;
    logic                           pick_valid_s, expire_s, all_locked_s;
    logic [SCORE_W-1:0]             cur_score_s;

    digit_entry #(.N_DIGITS(N_DIGITS), .CNT_W(CNT_W)) u_entry (
        .clk   (CLK),
        .rst_n (RST),
        .clr   (entry_clr_s),
        .shift (entry_shift_s),
        .digit (DIGIT),
        .entry (entry_s),
        .count (count_s)
    );

    // Buzzer arbitration: lowest-index unlocked buzzer wins.
    always_comb begin
        avail_s      = BUZZ & ~lock_r;
        pick_s       = 3'd0;
        pick_valid_s = 1'b0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            pick_s       = avail_s[i] ? 3'(i) : pick_s;
            pick_valid_s = pick_valid_s | avail_s[i];
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_nx      = state_r;
        round_nx      = round_r;
        answer_nx     = answer_r;
        time_nx       = time_r;
        lock_nx       = lock_r;
        active_nx     = active_r;
        score_nx      = score_r;
        res_nx        = 2'd0;
        ok_nx         = 1'b0;
        ng_nx         = 1'b0;
        entry_clr_s   = 1'b0;
        entry_shift_s = 1'b0;
        expire_s      = TICK && (time_r <= TIMER_W'(1));
        active_oh_s   = N_PLAYERS'(1) << active_r;
        all_locked_s  = &(lock_r | active_oh_s);
        cur_score_s   = score_r[int'(active_r)*SCORE_W +: SCORE_W];

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    state_nx    = ST_FETCH;
                    score_nx    = '0;
                    round_nx    = 8'd0;
                    lock_nx     = '0;
                    entry_clr_s = 1'b1;
                end else begin
                    state_nx = state_r;
                end
            end
            ST_FETCH: begin
                if (QUE_VALID) begin
                    answer_nx   = QUE_DATA;
                    time_nx     = TIMER_W'(TIME_LIMIT);
                    lock_nx     = '0;
                    entry_clr_s = 1'b1;
                    state_nx    = ST_WAIT;
                end else begin
                    state_nx = ST_FETCH;
                end
            end
            ST_WAIT: begin
                if (expire_s) begin
                    time_nx  = '0;
                    ng_nx    = 1'b1;
                    state_nx = ST_RESULT;
                end else begin
                    time_nx   = TICK ? time_r - TIMER_W'(1) : time_r;
                    active_nx = pick_valid_s ? pick_s : active_r;
                    state_nx  = pick_valid_s ? ST_ENTRY : ST_WAIT;
                end
            end
            ST_ENTRY: begin
                // Expiry beats a same-cycle ENTER; CLR beats a same-cycle digit or ENTER.
                if (expire_s) begin
                    time_nx  = '0;
                    ng_nx    = 1'b1;
                    state_nx = ST_RESULT;
                end else begin
                    time_nx       = TICK ? time_r - TIMER_W'(1) : time_r;
                    entry_clr_s   = CLR;
                    entry_shift_s = DIGIT_VALID && !CLR;
                    state_nx      = (ENTER && !CLR && (count_s != '0)) ? ST_JUDGE : ST_ENTRY;
                end
            end
            ST_JUDGE: begin
                if (entry_s == answer_r) begin
                    ok_nx    = 1'b1;
                    score_nx[int'(active_r)*SCORE_W +: SCORE_W] =
                        (cur_score_s == SCORE_MAX) ? SCORE_MAX : cur_score_s + SCORE_W'(1);
                    state_nx = ST_RESULT;
                end else begin
                    ng_nx       = 1'b1;
`ifdef QUIZ_PENALTY_EN
                    score_nx[int'(active_r)*SCORE_W +: SCORE_W] =
                        (cur_score_s == '0) ? '0 : cur_score_s - SCORE_W'(1);
`else
                    score_nx    = score_r;
`endif
                    lock_nx     = lock_r | active_oh_s;
                    entry_clr_s = 1'b1;
                    state_nx    = all_locked_s ? ST_RESULT : ST_WAIT;
                end
            end
            ST_RESULT: begin
                res_nx = res_r;
                if (TICK && (res_r == 2'd1)) begin
                    res_nx   = 2'd0;
                    round_nx = round_r + 8'd1;
                    state_nx = ((round_r + 8'd1) == 8'(ROUNDS)) ? ST_DONE : ST_FETCH;
                end else begin
                    res_nx = TICK ? res_r + 2'd1 : res_r;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        req_nx = (state_nx == ST_FETCH) && (state_r != ST_FETCH);
    end

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r  <= ST_IDLE;
            round_r  <= 8'd0;
            answer_r <= '0;
            time_r   <= '0;
            lock_r   <= '0;
            active_r <= 3'd0;
            score_r  <= '0;
            res_r    <= 2'd0;
            ok_r     <= 1'b0;
            ng_r     <= 1'b0;
            req_r    <= 1'b0;
            go_r     <= 1'b0;
        end else begin
            state_r  <= state_nx;
            round_r  <= round_nx;
            answer_r <= answer_nx;
            time_r   <= time_nx;
            lock_r   <= lock_nx;
            active_r <= active_nx;
            score_r  <= score_nx;
            res_r    <= res_nx;
            ok_r     <= ok_nx;
            ng_r     <= ng_nx;
            req_r    <= req_nx;
            go_r     <= (state_nx == ST_DONE);
        end
    end

    assign STATE     = state_r;
    assign ACTIVE    = active_r;
    assign ENTRY     = entry_s;
    assign TIME_LEFT = time_r;
    assign SCORE     = score_r;
    assign OK        = ok_r;
    assign NG        = ng_r;
    assign QUE_REQ   = req_r;
    assign GAME_OVER = go_r;

endmodule

// File: tb/tb_quiz_ctrl.sv
// Directed bench for quiz_ctrl: vector table for the basic game flow plus multi-cycle sequences.
module tb_quiz_ctrl;

    logic        CLK = 1'b0;
    logic        RST, START, TICK, QUE_VALID, DIGIT_VALID, CLR, ENTER;
    logic [23:0] QUE_DATA;
    logic [1:0]  BUZZ;
    logic [3:0]  DIGIT;
    logic        QUE_REQ, OK, NG, GAME_OVER;
    logic [2:0]  STATE, ACTIVE;
    logic [23:0] ENTRY;
    logic [7:0]  TIME_LEFT, SCORE;

    int n_vec = 0;
    int n_bad = 0;

`ifdef QUIZ_PENALTY_EN
    localparam logic [7:0] PEN_SC = 8'h00;
`else
    localparam logic [7:0] PEN_SC = 8'h01;
`endif

    quiz_ctrl dut (
        .CLK(CLK), .RST(RST), .START(START), .TICK(TICK), .QUE_DATA(QUE_DATA),
        .QUE_VALID(QUE_VALID), .QUE_REQ(QUE_REQ), .BUZZ(BUZZ), .DIGIT_VALID(DIGIT_VALID),
        .DIGIT(DIGIT), .CLR(CLR), .ENTER(ENTER), .STATE(STATE), .ACTIVE(ACTIVE),
        .ENTRY(ENTRY), .TIME_LEFT(TIME_LEFT), .SCORE(SCORE), .OK(OK), .NG(NG),
        .GAME_OVER(GAME_OVER)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        st, tk, qv;
        logic [23:0] qd;
        logic [1:0]  bz;
        logic        dv;
        logic [3:0]  dg;
        logic        cl, en;
        logic [2:0]  e_st, e_act;
        logic [23:0] e_ent;
        logic [7:0]  e_tl, e_sc;
        logic        e_ok, e_ng, e_req, e_go;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic st, logic tk, logic qv, logic [23:0] qd, logic [1:0] bz,
                                logic dv, logic [3:0] dg, logic cl, logic en,
                                logic [2:0] e_st, logic [2:0] e_act, logic [23:0] e_ent,
                                logic [7:0] e_tl, logic [7:0] e_sc,
                                logic e_ok, logic e_ng, logic e_req, logic e_go);
        vec_t v;
        v.st = st; v.tk = tk; v.qv = qv; v.qd = qd; v.bz = bz; v.dv = dv; v.dg = dg;
        v.cl = cl; v.en = en; v.e_st = e_st; v.e_act = e_act; v.e_ent = e_ent;
        v.e_tl = e_tl; v.e_sc = e_sc; v.e_ok = e_ok; v.e_ng = e_ng; v.e_req = e_req; v.e_go = e_go;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string nm, input logic [2:0] st, input logic [2:0] act,
                           input logic [23:0] ent, input logic [7:0] tl, input logic [7:0] sc,
                           input logic ok, input logic ng, input logic req, input logic go);
        chk({nm, ".STATE"}, 32'(STATE), 32'(st));
        chk({nm, ".ACTIVE"}, 32'(ACTIVE), 32'(act));
        chk({nm, ".ENTRY"}, 32'(ENTRY), 32'(ent));
        chk({nm, ".TIME_LEFT"}, 32'(TIME_LEFT), 32'(tl));
        chk({nm, ".SCORE"}, 32'(SCORE), 32'(sc));
        chk({nm, ".OK"}, 32'(OK), 32'(ok));
        chk({nm, ".NG"}, 32'(NG), 32'(ng));
        chk({nm, ".QUE_REQ"}, 32'(QUE_REQ), 32'(req));
        chk({nm, ".GAME_OVER"}, 32'(GAME_OVER), 32'(go));
    endtask

    task automatic clk1();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_in();
        START = 1'b0; TICK = 1'b0; QUE_VALID = 1'b0; QUE_DATA = 24'h0; BUZZ = 2'b00;
        DIGIT_VALID = 1'b0; DIGIT = 4'h0; CLR = 1'b0; ENTER = 1'b0;
    endtask

    task automatic do_start();   START = 1'b1; clk1(); idle_in(); endtask
    task automatic do_tick();    TICK = 1'b1; clk1(); idle_in(); endtask
    task automatic do_enter();   ENTER = 1'b1; clk1(); idle_in(); endtask
    task automatic do_buzz(input logic [1:0] b);  BUZZ = b; clk1(); idle_in(); endtask
    task automatic do_digit(input logic [3:0] d); DIGIT_VALID = 1'b1; DIGIT = d; clk1(); idle_in(); endtask
    task automatic do_que(input logic [23:0] d);  QUE_VALID = 1'b1; QUE_DATA = d; clk1(); idle_in(); endtask
    task automatic do_ticks(input int n);
        for (int k = 0; k < n; k++) do_tick();
    endtask

    initial begin
        idle_in();
        RST = 1'b0;
        clk1();
        clk1();
        chk_all("reset", 3'd0, 3'd0, 24'h0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        RST = 1'b1;
        clk1();

        // Round 1: player 1 answers 012345 correctly; round 2: arbitration, wrong answer, lockout.
        tbl.push_back(mk(1'b1,1'b0,1'b0,24'h0,2'b00,1'b0,4'h0,1'b0,1'b0, 3'd1,3'd0,24'h000000,8'd0,8'h00,1'b0,1'b0,1'b1,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,24'h0,2'b00,1'b0,4'h0,1'b0,1'b0, 3'd1,3'd0,24'h000000,8'd0,8'h00,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b1,24'h012345,2'b00,1'b0,4'h0,1'b0,1'b0, 3'd2,3'd0,24'h000000,8'd30,8'h00,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,24'h0,2'b10,1'b0,4'h0,1'b0,1'b0, 3'd3,3'd1,24'h000000,8'd30,8'h00,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,24'h0,2'b00,1'b1,4'h0,1'b0,1'b0, 3'd3,3'd1,24'h000000,8'd30,8'h00,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,24'h0,2'b00,1'b1,4'h1,1'b0,1'b0, 3'd3,3'd1,24'h000001,8'd30,8'h00,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,24'h0,2'b00,1'b1,4'h2,1'b0,1'b0, 3'd3,3'd1,24'h000012,8'd30,8'h00,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,24'h0,2'b00,1'b1,4'h3,1'b0,1'b0, 3'd3,3'd1,24'h000123,8'd30,8'h00,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,24'h0,2'b00,1'b1,4'h4,1'b0,1'b0, 3'd3,3'd1,24'h001234,8'd30,8'h00,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,24'h0,2'b00,1'b1,4'h5,1'b0,1'b0, 3'd3,3'd1,24'h012345,8'd30,8'h00,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,24'h0,2'b00,1'b0,4'h0,1'b0,1'b1, 3'd4,3'd1,24'h012345,8'd30,8'h00,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,24'h0,2'b00,1'b0,4'h0,1'b0,1'b0, 3'd5,3'd1,24'h012345,8'd30,8'h10,1'b1,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,24'h0,2'b00,1'b0,4'h0,1'b0,1'b0, 3'd5,3'd1,24'h012345,8'd30,8'h10,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,24'h0,2'b00,1'b0,4'h0,1'b0,1'b0, 3'd5,3'd1,24'h012345,8'd30,8'h10,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,24'h0,2'b00,1'b0,4'h0,1'b0,1'b0, 3'd1,3'd1,24'h012345,8'd30,8'h10,1'b0,1'b0,1'b1,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b1,24'h000007,2'b00,1'b0,4'h0,1'b0,1'b0, 3'd2,3'd1,24'h000000,8'd30,8'h10,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,24'h0,2'b11,1'b0,4'h0,1'b0,1'b0, 3'd3,3'd0,24'h000000,8'd30,8'h10,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,24'h0,2'b00,1'b1,4'h9,1'b0,1'b0, 3'd3,3'd0,24'h000009,8'd30,8'h10,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,24'h0,2'b00,1'b1,4'h9,1'b0,1'b0, 3'd3,3'd0,24'h000099,8'd30,8'h10,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,24'h0,2'b00,1'b1,4'h9,1'b0,1'b0, 3'd3,3'd0,24'h000999,8'd30,8'h10,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,24'h0,2'b00,1'b1,4'h9,1'b0,1'b0, 3'd3,3'd0,24'h009999,8'd30,8'h10,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,24'h0,2'b00,1'b1,4'h9,1'b0,1'b0, 3'd3,3'd0,24'h099999,8'd30,8'h10,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,24'h0,2'b00,1'b1,4'h9,1'b0,1'b0, 3'd3,3'd0,24'h999999,8'd30,8'h10,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,24'h0,2'b00,1'b0,4'h0,1'b0,1'b1, 3'd4,3'd0,24'h999999,8'd30,8'h10,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,24'h0,2'b00,1'b0,4'h0,1'b0,1'b0, 3'd2,3'd0,24'h000000,8'd30,8'h10,1'b0,1'b1,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,24'h0,2'b01,1'b0,4'h0,1'b0,1'b0, 3'd2,3'd0,24'h000000,8'd30,8'h10,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,24'h0,2'b10,1'b0,4'h0,1'b0,1'b0, 3'd3,3'd1,24'h000000,8'd30,8'h10,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,24'h0,2'b00,1'b1,4'h7,1'b0,1'b0, 3'd3,3'd1,24'h000007,8'd30,8'h10,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,24'h0,2'b00,1'b0,4'h0,1'b0,1'b1, 3'd4,3'd1,24'h000007,8'd30,8'h10,1'b0,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,24'h0,2'b00,1'b0,4'h0,1'b0,1'b0, 3'd5,3'd1,24'h000007,8'd30,8'h20,1'b1,1'b0,1'b0,1'b0));

        for (int i = 0; i < tbl.size(); i++) begin
            START = tbl[i].st; TICK = tbl[i].tk; QUE_VALID = tbl[i].qv; QUE_DATA = tbl[i].qd;
            BUZZ = tbl[i].bz; DIGIT_VALID = tbl[i].dv; DIGIT = tbl[i].dg; CLR = tbl[i].cl;
            ENTER = tbl[i].en;
            clk1();
            chk_all($sformatf("vec%0d", i), tbl[i].e_st, tbl[i].e_act, tbl[i].e_ent, tbl[i].e_tl,
                    tbl[i].e_sc, tbl[i].e_ok, tbl[i].e_ng, tbl[i].e_req, tbl[i].e_go);
        end
        idle_in();

        // Round 3: nobody buzzes, timer runs out.
        do_ticks(2);
        chk("to.fetch_state", 32'(STATE), 32'd1);
        chk("to.fetch_req", 32'(QUE_REQ), 32'd1);
        do_que(24'h000001);
        chk("to.time_load", 32'(TIME_LEFT), 32'd30);
        do_ticks(29);
        chk("to.time_one", 32'(TIME_LEFT), 32'd1);
        chk("to.still_wait", 32'(STATE), 32'd2);
        do_tick();
        chk_all("to.expire", 3'd5, 3'd1, 24'h0, 8'd0, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0);
        do_ticks(2);
        chk("to.refetch_state", 32'(STATE), 32'd1);
        chk("to.refetch_req", 32'(QUE_REQ), 32'd1);

        // Round 4: entry overflow, non-BCD digit, CLR priority, empty ENTER, buzz during entry.
        do_que(24'h123456);
        do_buzz(2'b01);
        chk("en.active", 32'(ACTIVE), 32'd0);
        do_enter();
        chk("en.empty_enter", 32'(STATE), 32'd3);
        for (int d = 1; d <= 7; d++) do_digit(4'(d));
        chk("en.overflow", 32'(ENTRY), 32'h123456);
        do_digit(4'hA);
        chk("en.non_bcd", 32'(ENTRY), 32'h123456);
        do_buzz(2'b10);
        chk("en.buzz_ignored", 32'(ACTIVE), 32'd0);
        DIGIT_VALID = 1'b1; DIGIT = 4'h8; CLR = 1'b1; clk1(); idle_in();
        chk("en.clr_wins", 32'(ENTRY), 32'h0);
        do_digit(4'h3);
        chk("en.after_clr", 32'(ENTRY), 32'h3);
        CLR = 1'b1; clk1(); idle_in();
        for (int d = 1; d <= 6; d++) do_digit(4'(d));
        do_enter();
        clk1();
        chk_all("en.correct", 3'd5, 3'd0, 24'h123456, 8'd30, 8'h21, 1'b1, 1'b0, 1'b0, 1'b0);
        do_ticks(2);

        // Round 5: ENTER coincides with timer expiry; expiry wins, then the game ends.
        do_que(24'h000001);
        do_buzz(2'b01);
        do_ticks(29);
        do_digit(4'h1);
        TICK = 1'b1; ENTER = 1'b1; clk1(); idle_in();
        chk_all("exp.enter", 3'd5, 3'd0, 24'h000001, 8'd0, 8'h21, 1'b0, 1'b1, 1'b0, 1'b0);
        do_ticks(2);
        chk_all("g1.done", 3'd6, 3'd0, 24'h000001, 8'd0, 8'h21, 1'b0, 1'b0, 1'b0, 1'b1);

        // Game 2: five correct rounds by player 0, with a stray START mid-entry.
        do_start();
        chk("g2.start_clears", 32'(SCORE), 32'h00);
        chk("g2.go_low", 32'(GAME_OVER), 32'd0);
        for (int r = 0; r < 5; r++) begin
            do_que(24'h000042);
            do_buzz(2'b01);
            do_digit(4'h4);
            if (r == 0) begin
                do_start();
                chk("g2.start_ignored", 32'(STATE), 32'd3);
            end
            do_digit(4'h2);
            do_enter();
            clk1();
            chk($sformatf("g2.ok%0d", r), 32'(OK), 32'd1);
            do_ticks(2);
        end
        chk("g2.state_done", 32'(STATE), 32'd6);
        chk("g2.game_over", 32'(GAME_OVER), 32'd1);
        chk("g2.score5", 32'(SCORE), 32'h05);

        // Game 3: wrong answers (penalty build dependent), all-locked exit, reset mid-entry.
        do_start();
        do_que(24'h000042);
        do_buzz(2'b01);
        do_digit(4'h4);
        do_digit(4'h2);
        do_enter();
        clk1();
        chk("g3.score1", 32'(SCORE), 32'h01);
        do_ticks(2);
        do_que(24'h000042);
        do_buzz(2'b01);
        do_digit(4'h9);
        do_enter();
        clk1();
        chk_all("g3.wrong0", 3'd2, 3'd0, 24'h0, 8'd30, PEN_SC, 1'b0, 1'b1, 1'b0, 1'b0);
        do_buzz(2'b10);
        chk("g3.p1_active", 32'(ACTIVE), 32'd1);
        do_digit(4'h9);
        do_enter();
        clk1();
        chk_all("g3.wrong1", 3'd5, 3'd1, 24'h0, 8'd30, PEN_SC, 1'b0, 1'b1, 1'b0, 1'b0);
        do_ticks(2);
        do_start();
        chk("g3.start_in_fetch", 32'(STATE), 32'd1);
        do_que(24'h000042);
        do_buzz(2'b10);
        do_digit(4'h1);
        chk("g3.mid_entry", 32'(STATE), 32'd3);
        RST = 1'b0;
        clk1();
        chk_all("g3.reset", 3'd0, 3'd0, 24'h0, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        RST = 1'b1;
        clk1();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/quiz_ctrl.md
QUIZ_CTRL -- requirements
Module: quiz_ctrl

Interface
REQ-001 SHALL have parameter N_PLAYERS, default 2, meaning number of buzzer channels (1..8).
REQ-002 SHALL have parameter N_DIGITS, default 6, meaning BCD answer length in nibbles.
REQ-003 SHALL have parameter TIME_LIMIT, default 30, meaning TICK pulses allowed per question.
REQ-004 SHALL have parameter ROUNDS, default 5, meaning questions per game.
REQ-005 SHALL have parameter SCORE_W, default 4, meaning per-player score width.
REQ-006 SHALL have ports, one per line:
- CLK  in  1  system clock
- RST  in  1  reset; one clock; reset is synchronous and active-low
- START  in  1  one-cycle pulse, begin game
- TICK  in  1  one-cycle 1 Hz pulse from an external prescaler
- QUE_DATA  in  4*N_DIGITS  expected BCD answer from question DB
- QUE_VALID  in  1  QUE_DATA valid, one-cycle pulse
- QUE_REQ  out  1  one-cycle request for next question
- BUZZ  in  N_PLAYERS  one-cycle buzzer pulses
- DIGIT_VALID  in  1  DIGIT strobe
- DIGIT  in  4  entered BCD digit
- CLR  in  1  clear entry pulse
- ENTER  in  1  submit entry pulse
- STATE  out  3  FSM state code
- ACTIVE  out  3  answering player index
- ENTRY  out  4*N_DIGITS  current entry, MS nibble first
- TIME_LEFT  out  8  remaining ticks
- SCORE  out  SCORE_W*N_PLAYERS  packed scores, player 0 in LS field
- OK  out  1  one-cycle correct-answer pulse
- NG  out  1  one-cycle wrong-answer/timeout pulse
- GAME_OVER  out  1  level, high in DONE

Function
REQ-007 SHALL implement states IDLE, FETCH, WAIT_BUZZ, ENTRY, JUDGE, RESULT, DONE.
REQ-008 IDLE: START -> FETCH, clearing scores, round counter, lockouts.
REQ-009 FETCH: QUE_REQ pulses on the first FETCH cycle only; QUE_VALID latches QUE_DATA, reloads TIME_LEFT=TIME_LIMIT, clears lockouts and entry -> WAIT_BUZZ.
REQ-010 WAIT_BUZZ: first non-locked BUZZ bit wins; simultaneous bits -> lowest index wins; ACTIVE latched -> ENTRY; locked-out bits ignored.
REQ-011 ENTRY: DIGIT_VALID with DIGIT<=9 shifts entry left one nibble, new digit into LS nibble; DIGIT>9 ignored; once N_DIGITS digits are held, further digits ignored.
REQ-012 CLR clears entry and digit count; CLR and DIGIT_VALID in the same cycle -> CLR wins.
REQ-013 ENTER in ENTRY -> JUDGE; ENTER with zero digits ignored; BUZZ ignored in ENTRY.
REQ-014 JUDGE (one cycle): entry==latched answer -> OK pulse, ACTIVE score +1 saturating at 2^SCORE_W-1, -> RESULT; else NG pulse, ACTIVE locked out, entry cleared, -> WAIT_BUZZ, or -> RESULT if all players are locked out.
REQ-015 Timer: TIME_LEFT decrements on TICK in WAIT_BUZZ and ENTRY; on reaching 0 -> NG pulse, no score change, -> RESULT; timer frozen elsewhere.
REQ-016 RESULT holds for 2 TICKs, then increments round; round==ROUNDS -> DONE, else -> FETCH.
REQ-017 DONE: GAME_OVER=1, scores held; START -> IDLE-equivalent restart (REQ-008).
REQ-018 START outside IDLE/DONE SHALL be ignored.
REQ-019 ENTER in the same cycle as timer expiry: expiry wins.

Reset
REQ-020 RST low at a CLK edge SHALL force IDLE; all outputs 0 (SCORE, ENTRY, TIME_LEFT, ACTIVE, STATE=IDLE code 0, pulses low), mid-game included.

Configuration
REQ-021 With QUIZ_PENALTY_EN defined, a wrong answer in JUDGE SHALL decrement the ACTIVE score, saturating at 0; without it, a wrong answer leaves scores unchanged.

Structure
REQ-022 Package quiz_pkg SHALL hold the state encoding and the TICK/timer width constant.
REQ-023 Digit shift register and count SHALL be sub-module digit_entry.

Verification
REQ-024 Default parameters; START, QUE_DATA=0x012345, BUZZ=2'b10, digits 0,1,2,3,4,5, ENTER -> OK pulse, SCORE[7:4]=1, ACTIVE=1.
REQ-025 BUZZ=2'b11 same cycle -> ACTIVE=0; wrong entry 999999 -> NG, player 0 locked; BUZZ[0] ignored; BUZZ[1] accepted.
REQ-026 No buzz for 30 TICKs -> TIME_LEFT 30->0, NG, scores unchanged, RESULT then FETCH with QUE_REQ.
REQ-027 Seven digits entered -> ENTRY holds first six; digit 0xA ignored; CLR with DIGIT_VALID -> ENTRY=0.
REQ-028 Five correct rounds -> GAME_OVER=1, score 5; RST low mid-ENTRY -> all outputs 0 next edge.
REQ-029 With QUIZ_PENALTY_EN, score 1 then wrong answer -> 0; second wrong answer by another player at score 0 stays 0.
